// File: rtl/cacheline_adaptor_if.sv
// Line-request and burst-memory signal bundle for the cacheline adaptor.
// slave is the adaptor side; master is the arbiter/memory side.
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i,
    input  burst_i, resp_i,
    output line_o, resp_o, address_o,
    output read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i,
    output burst_i, resp_i,
    input  line_o, resp_o, address_o,
    input  read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Line <-> burst adaptor between the I/D arbiter and physical memory.
// One transaction at a time; reads fill a line buffer, writes stream a latched line.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wr_q;
  logic [LINE_W-1:0]  rd_q;
  logic               accept;
  logic               last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    last    = (cnt_q == CNT_W'(BEATS - 1));
    unique case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          accept  = 1'b1;
          state_d = WRITE;
        end else if (bus.read_i) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ, WRITE: begin
        if (bus.resp_i) begin
          if (last) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and write line are frozen at accept so mid-flight request changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      if (accept)
        addr_q <= {bus.address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
      if (accept && bus.write_i)
        wr_q <= bus.line_i;
      if (state_q == READ && bus.resp_i)
        rd_q[cnt_q*BURST_W +: BURST_W] <= bus.burst_i;
    end
  end

  always_comb begin
    bus.read_o    = (state_q == READ);
    bus.write_o   = (state_q == WRITE);
    bus.resp_o    = (state_q == DONE);
    bus.address_o = addr_q;
    bus.line_o    = rd_q;
    bus.burst_o   = wr_q[cnt_q*BURST_W +: BURST_W];
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor.
// Inputs driven and outputs sampled on the falling edge.
module tb_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  cacheline_adaptor_if #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) bus ();

  cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [255:0] prev_line;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (bus.resp_o !== 1'b0) begin errs++; $display("FAIL rst_resp got %h exp 0", bus.resp_o); end
    vecs++; if (bus.read_o !== 1'b0) begin errs++; $display("FAIL rst_read got %h exp 0", bus.read_o); end
    vecs++; if (bus.write_o !== 1'b0) begin errs++; $display("FAIL rst_write got %h exp 0", bus.write_o); end
    vecs++; if (bus.address_o !== 32'h0) begin errs++; $display("FAIL rst_addr got %h exp 0", bus.address_o); end
    vecs++; if (bus.burst_o !== 64'h0) begin errs++; $display("FAIL rst_burst got %h exp 0", bus.burst_o); end
    vecs++; if (bus.line_o !== 256'h0) begin errs++; $display("FAIL rst_line got %h exp 0", bus.line_o); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    logic [63:0] b [4];
    logic [255:0] exp_line;
    b = '{64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
          64'hCCCC_0000_0000_0003, 64'hDDDD_0000_0000_0004};
    exp_line = {b[3], b[2], b[1], b[0]};
    bus.address_i = 32'h0000_1234;
    bus.read_i = 1'b1;
    @(negedge clk);
    vecs++; if (bus.read_o !== 1'b1) begin errs++; $display("FAIL rd_read_o got %h exp 1", bus.read_o); end
    vecs++; if (bus.address_o !== 32'h0000_1220) begin errs++; $display("FAIL rd_addr got %h exp 00001220", bus.address_o); end
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = b[i];
      @(negedge clk);
      if (i < 3) begin
        vecs++; if (bus.resp_o !== 1'b0) begin errs++; $display("FAIL rd_early_resp beat %0d got %h exp 0", i, bus.resp_o); end
      end
    end
    bus.resp_i = 1'b0;
    vecs++; if (bus.resp_o !== 1'b1) begin errs++; $display("FAIL rd_resp got %h exp 1", bus.resp_o); end
    vecs++; if (bus.line_o !== exp_line) begin errs++; $display("FAIL rd_line got %h exp %h", bus.line_o, exp_line); end
    vecs++; if (bus.read_o !== 1'b0) begin errs++; $display("FAIL rd_read_done got %h exp 0", bus.read_o); end
    bus.read_i = 1'b0;
    @(negedge clk);
    vecs++; if (bus.resp_o !== 1'b0) begin errs++; $display("FAIL rd_resp_one got %h exp 0", bus.resp_o); end
    vecs++; if (bus.line_o !== exp_line) begin errs++; $display("FAIL rd_line_hold got %h exp %h", bus.line_o, exp_line); end
    prev_line = exp_line;
  endtask

  task automatic test_write();
    logic [63:0] w [4];
    w = '{64'h1111_2222_3333_4440, 64'h1111_2222_3333_4441,
          64'h1111_2222_3333_4442, 64'h1111_2222_3333_4443};
    bus.address_i = 32'h0000_0040;
    bus.line_i = {w[3], w[2], w[1], w[0]};
    bus.write_i = 1'b1;
    @(negedge clk);
    bus.line_i = '1;
    vecs++; if (bus.address_o !== 32'h0000_0040) begin errs++; $display("FAIL wr_addr got %h exp 00000040", bus.address_o); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (bus.write_o !== 1'b1) begin errs++; $display("FAIL wr_write_o beat %0d got %h exp 1", i, bus.write_o); end
      vecs++; if (bus.burst_o !== w[i]) begin errs++; $display("FAIL wr_burst beat %0d got %h exp %h", i, bus.burst_o, w[i]); end
      bus.resp_i = 1'b1;
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    vecs++; if (bus.resp_o !== 1'b1) begin errs++; $display("FAIL wr_resp got %h exp 1", bus.resp_o); end
    vecs++; if (bus.write_o !== 1'b0) begin errs++; $display("FAIL wr_write_drop got %h exp 0", bus.write_o); end
    vecs++; if (bus.line_o !== prev_line) begin errs++; $display("FAIL wr_line_kept got %h exp %h", bus.line_o, prev_line); end
    bus.write_i = 1'b0;
    @(negedge clk);
    vecs++; if (bus.resp_o !== 1'b0) begin errs++; $display("FAIL wr_resp_one got %h exp 0", bus.resp_o); end
  endtask

  task automatic test_gapped();
    logic [63:0] g [4];
    logic [6:0] pat;
    logic [255:0] exp_line;
    int k;
    g = '{64'h0123_4567_89AB_CDE0, 64'h0123_4567_89AB_CDE1,
          64'h0123_4567_89AB_CDE2, 64'h0123_4567_89AB_CDE3};
    pat = 7'b1011001;
    exp_line = {g[3], g[2], g[1], g[0]};
    k = 0;
    bus.address_i = 32'h0000_013F;
    bus.read_i = 1'b1;
    @(negedge clk);
    vecs++; if (bus.address_o !== 32'h0000_0120) begin errs++; $display("FAIL gap_addr got %h exp 00000120", bus.address_o); end
    for (int i = 0; i < 7; i++) begin
      bus.resp_i = pat[6-i];
      if (pat[6-i]) begin
        bus.burst_i = g[k];
        k++;
      end else begin
        bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      @(negedge clk);
      if (i < 6) begin
        vecs++; if (bus.resp_o !== 1'b0) begin errs++; $display("FAIL gap_early_resp cyc %0d got %h exp 0", i, bus.resp_o); end
        vecs++; if (bus.read_o !== 1'b1) begin errs++; $display("FAIL gap_read_o cyc %0d got %h exp 1", i, bus.read_o); end
      end
    end
    bus.resp_i = 1'b0;
    vecs++; if (bus.resp_o !== 1'b1) begin errs++; $display("FAIL gap_resp got %h exp 1", bus.resp_o); end
    vecs++; if (bus.line_o !== exp_line) begin errs++; $display("FAIL gap_line got %h exp %h", bus.line_o, exp_line); end
    bus.read_i = 1'b0;
    @(negedge clk);
    vecs++; if (bus.resp_o !== 1'b0) begin errs++; $display("FAIL gap_resp_one got %h exp 0", bus.resp_o); end
    prev_line = exp_line;
  endtask

  task automatic test_both();
    logic [63:0] w [4];
    int nresp;
    w = '{64'hF0F0_0000_0000_0000, 64'hF0F0_0000_0000_0001,
          64'hF0F0_0000_0000_0002, 64'hF0F0_0000_0000_0003};
    nresp = 0;
    bus.address_i = 32'h0000_0085;
    bus.line_i = {w[3], w[2], w[1], w[0]};
    bus.read_i = 1'b1;
    bus.write_i = 1'b1;
    @(negedge clk);
    vecs++; if (bus.address_o !== 32'h0000_0080) begin errs++; $display("FAIL both_addr got %h exp 00000080", bus.address_o); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (bus.write_o !== 1'b1) begin errs++; $display("FAIL both_write_o beat %0d got %h exp 1", i, bus.write_o); end
      vecs++; if (bus.read_o !== 1'b0) begin errs++; $display("FAIL both_read_o beat %0d got %h exp 0", i, bus.read_o); end
      vecs++; if (bus.burst_o !== w[i]) begin errs++; $display("FAIL both_burst beat %0d got %h exp %h", i, bus.burst_o, w[i]); end
      bus.resp_i = 1'b1;
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    if (bus.resp_o) nresp++;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_o) nresp++;
    end
    vecs++; if (nresp !== 1) begin errs++; $display("FAIL both_resp_count got %0d exp 1", nresp); end
    vecs++; if (bus.line_o !== prev_line) begin errs++; $display("FAIL both_line_kept got %h exp %h", bus.line_o, prev_line); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e [4];
    logic [255:0] exp_line;
    e = '{64'hE000_0000_0000_0010, 64'hE000_0000_0000_0011,
          64'hE000_0000_0000_0012, 64'hE000_0000_0000_0013};
    exp_line = {e[3], e[2], e[1], e[0]};
    bus.address_i = 32'h0000_0200;
    bus.read_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = 64'h5555_5555_5555_5550 | 64'(i);
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vecs++; if (bus.read_o !== 1'b0) begin errs++; $display("FAIL rmid_read got %h exp 0", bus.read_o); end
    vecs++; if (bus.resp_o !== 1'b0) begin errs++; $display("FAIL rmid_resp got %h exp 0", bus.resp_o); end
    vecs++; if (bus.line_o !== 256'h0) begin errs++; $display("FAIL rmid_line got %h exp 0", bus.line_o); end
    vecs++; if (bus.address_o !== 32'h0) begin errs++; $display("FAIL rmid_addr got %h exp 0", bus.address_o); end
    rst = 1'b0;
    bus.address_i = 32'h0000_0300;
    bus.read_i = 1'b1;
    @(negedge clk);
    vecs++; if (bus.read_o !== 1'b1) begin errs++; $display("FAIL rmid_fresh_read got %h exp 1", bus.read_o); end
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = e[i];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    vecs++; if (bus.resp_o !== 1'b1) begin errs++; $display("FAIL rmid_fresh_resp got %h exp 1", bus.resp_o); end
    vecs++; if (bus.line_o !== exp_line) begin errs++; $display("FAIL rmid_fresh_line got %h exp %h", bus.line_o, exp_line); end
    bus.read_i = 1'b0;
    @(negedge clk);
    prev_line = exp_line;
  endtask

  task automatic test_back_to_back();
    logic [63:0] r [4];
    logic [63:0] w [4];
    logic [255:0] exp_line;
    int rd_resp;
    int wr_resp;
    r = '{64'h7000_0000_0000_00A0, 64'h7000_0000_0000_00A1,
          64'h7000_0000_0000_00A2, 64'h7000_0000_0000_00A3};
    w = '{64'h9000_0000_0000_00B0, 64'h9000_0000_0000_00B1,
          64'h9000_0000_0000_00B2, 64'h9000_0000_0000_00B3};
    exp_line = {r[3], r[2], r[1], r[0]};
    rd_resp = 0;
    wr_resp = 0;
    for (int i = 0; i < 3; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      vecs++; if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000) begin errs++; $display("FAIL idle_outs cyc %0d got %b exp 000", i, {bus.resp_o, bus.read_o, bus.write_o}); end
    end
    bus.resp_i = 1'b0;
    vecs++; if (bus.line_o !== prev_line) begin errs++; $display("FAIL idle_line got %h exp %h", bus.line_o, prev_line); end
    bus.address_i = 32'h0000_0400;
    bus.read_i = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.resp_o) begin
        if (cyc <= 6) rd_resp++;
        else wr_resp++;
      end
      bus.resp_i = 1'b0;
      if (cyc >= 1 && cyc <= 4) begin
        bus.resp_i = 1'b1;
        bus.burst_i = r[cyc-1];
      end
      if (cyc == 5) begin
        vecs++; if (bus.line_o !== exp_line) begin errs++; $display("FAIL b2b_line got %h exp %h", bus.line_o, exp_line); end
        bus.read_i = 1'b0;
        bus.write_i = 1'b1;
        bus.address_i = 32'h0000_0460;
        bus.line_i = {w[3], w[2], w[1], w[0]};
      end
      if (cyc >= 7 && cyc <= 10) begin
        vecs++; if (bus.burst_o !== w[cyc-7]) begin errs++; $display("FAIL b2b_burst beat %0d got %h exp %h", cyc - 7, bus.burst_o, w[cyc-7]); end
        bus.resp_i = 1'b1;
      end
      if (cyc == 7) begin
        vecs++; if (bus.address_o !== 32'h0000_0460) begin errs++; $display("FAIL b2b_waddr got %h exp 00000460", bus.address_o); end
      end
      if (cyc == 11) bus.write_i = 1'b0;
    end
    bus.resp_i = 1'b0;
    vecs++; if (rd_resp !== 1) begin errs++; $display("FAIL b2b_rd_resp_count got %0d exp 1", rd_resp); end
    vecs++; if (wr_resp !== 1) begin errs++; $display("FAIL b2b_wr_resp_count got %0d exp 1", wr_resp); end
  endtask

  initial begin
    bus.address_i = '0;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.line_i = '0;
    bus.burst_i = '0;
    bus.resp_i = 1'b0;
    prev_line = '0;
    test_reset();
    test_read();
    test_write();
    test_gapped();
    test_both();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
